// File: rtl/state_display_pkg.sv
// Shared constants for the traffic-state display: segment patterns and scan slot indices.
package state_display_pkg;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [1:0] IDX_CODE = 2'd0;
  localparam logic [1:0] IDX_MODE = 2'd1;
  localparam logic [1:0] IDX_ONES = 2'd2;
  localparam logic [1:0] IDX_TENS = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; values above 9 blank the digit.
module seg7_decode
  import state_display_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (value_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/state_display.sv
// Synchronises the traffic-state code, counts its changes in BCD and scans a 4-digit display.
// Define STATE_DISPLAY_LZB_EN to blank the tens digit while it is zero.
module state_display
  import state_display_pkg::*;
#(
  parameter logic [23:0] CLOCK    = 24'd12000000,
  parameter logic [15:0] SCAN_DIV = 16'd12000
) (
  input  logic       clk,
  input  logic       CR,
  input  logic [2:0] data,
  input  logic       M,
  output logic [7:0] seg,
  output logic [3:0] dig
);

  logic [2:0]  d_s1_q, d_s2_q, d_prev_q;
  logic        m_s1_q, m_s2_q;
  logic [3:0]  ones_q, ones_d, tens_q, tens_d;
  logic [15:0] scan_q, scan_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  dig_q, dig_d;
  logic        chg, scan_last;
  logic [3:0]  digit_val;
  logic [6:0]  dec_seg;

  // The clock frequency only documents the intended scan rate.
  logic unused_clock;
  assign unused_clock = ^CLOCK;

  seg7_decode u_seg7_decode (
    .value_i (digit_val),
    .seg_o   (dec_seg)
  );

  always_comb begin
    chg    = (d_s2_q != d_prev_q);
    ones_d = ones_q;
    tens_d = tens_q;
    if (chg) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end

    scan_last = (scan_q == SCAN_DIV - 16'd1);
    scan_d    = scan_last ? 16'd0 : scan_q + 16'd1;
    idx_d     = scan_last ? idx_q + 2'd1 : idx_q;

    digit_val = tens_q;
    unique case (idx_q)
      IDX_CODE: digit_val = {1'b0, d_s2_q};
      IDX_MODE: digit_val = {3'b000, m_s2_q};
      IDX_ONES: digit_val = ones_q;
      IDX_TENS: digit_val = tens_q;
    endcase

    seg_d = {1'b1, dec_seg};
    dig_d = ~(4'b0001 << idx_q);
`ifdef STATE_DISPLAY_LZB_EN
    if (idx_q == IDX_TENS && tens_q == 4'd0) begin
      seg_d = SEG_OFF;
      dig_d = 4'hF;
    end
`endif
  end

  // Sync stages reset to the upstream reset code so reset release produces no count.
  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      d_s1_q   <= 3'b111;
      d_s2_q   <= 3'b111;
      d_prev_q <= 3'b111;
      m_s1_q   <= 1'b0;
      m_s2_q   <= 1'b0;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      scan_q   <= 16'd0;
      idx_q    <= 2'd0;
      seg_q    <= SEG_OFF;
      dig_q    <= 4'hF;
    end else begin
      d_s1_q   <= data;
      d_s2_q   <= d_s1_q;
      d_prev_q <= d_s2_q;
      m_s1_q   <= M;
      m_s2_q   <= m_s1_q;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

endmodule

// File: doc/state_display.md
Name: state_display

Overview:
- Downstream consumer of the 3-bit traffic-state code and the mode switch M.
- Synchronises the code into the board clock domain and counts code changes in BCD (00–99).
- Time-multiplexes code, mode and change count onto a 4-digit common-anode 7-segment display.
- The code is produced in a divided-clock domain, so it is treated as asynchronous.

Parameters:
- CLOCK, 24'd12000000, board oscillator frequency in Hz.
- SCAN_DIV, 16'd12000, clk cycles per digit slot (1 kHz per digit, 250 Hz full refresh at 12 MHz).

Ports:
- clk  input  1  board clock, 12 MHz.
- CR  input  1  asynchronous active-low reset.
- data  input  3  state code from upstream; asynchronous to clk.
- M  input  1  mode switch; quasi-static, synchronised like data.
- seg  output  8  {dp,g,f,e,d,c,b,a}; active-low (0 = segment lit).
- dig  output  4  digit enables; one-hot active-low (0 = digit on); dig[0] is the rightmost digit.

Behaviour:
- Reset (CR=0, asynchronous):
  - seg=8'hFF, dig=4'hF.
  - Synchroniser stages and previous-code register = 3'b111, which matches the upstream reset code, so no count is generated on reset release.
  - M sync = 0, count = 00, scan counter = 0, digit index = 0.
- Synchronisation:
  - data passes through two flops: d_s1, then d_s2.
  - M passes through two flops.
- Change detection:
  - d_prev <= d_s2 every cycle.
  - Pulse chg = (d_s2 != d_prev), one cycle wide.
  - Latency from a data edge to the count update is 3 clk cycles.
- Counter:
  - Two BCD digits (ones, tens).
  - Increments on chg; ones 9→0 carries into tens.
  - 99→00 wraps; no saturation.
  - Count updates only on chg; M changes do not count.
- Scan:
  - A free-running counter counts 0..SCAN_DIV-1.
  - At terminal count, digit index advances 0→1→2→3→0.
  - seg and dig are registered, so the display content for a new index appears 1 cycle after the index changes.
- Digit contents:
  - idx0: code value in octal, 0–7.
  - idx1: M value, 0 or 1.
  - idx2: count ones.
  - idx3: count tens.
  - dp is always off (1).
- Encoding (7 bits, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any value >9: all segments off (1111111).
- dig = ~(4'b0001 << idx).
- Exactly one digit is active at a time, except during reset, when none is.
- Reset asserted mid-scan: outputs blank immediately (asynchronous); the count is lost.

Optional Feature:
- Macro: STATE_DISPLAY_LZB_EN.
- Defined: the tens digit is blanked (dig[3] driven 1, seg=8'hFF in slot 3) while tens==0. Slot timing is unchanged.
- Undefined: tens digit always shown, including a leading 0.

Decomposition:
- Package state_display_pkg:
  - SEG_OFF constant.
  - The 10-entry digit-to-segment constants.
  - Digit-index localparams.
- One sub-module, seg7_decode:
  - Combinational, 4-bit value in, 7-bit active-low segments out.
  - Values >9 produce blank.
  - Instantiated once on the muxed digit value.

Test Plan:
- Reset release with data=111, M=0, held for 10 ms → count stays 00. Over one full scan, dig cycles E,D,B,7; seg in slot0 shows "7" (1111000), slot1 "0", slots 2–3 "0".
- Step data 111→000→110→010, one change every 1000 clk → count reaches 03 exactly 3 cycles after the last edge; slot2 seg=0110000, slot3 "0".
- Apply 100 data changes → count wraps to 00; check the 9→10 carry (ones 0, tens 1) and 99→00.
- Toggle M 0→1 with data held → slot1 shows "1" (1111001) within 2 sync cycles plus the next slot1 window; count unchanged.
- Assert CR=0 mid-slot after count=57 → seg=FF and dig=F in the same cycle. After release, count=00 and idx=0.
- With STATE_DISPLAY_LZB_EN defined and count=05 → in slot3, dig=4'hF and seg=FF. At count=10, slot3 shows "1".
